simon_round_ctrl: RTL and testbench
===================================

# simon_round_ctrl

Round sequencer for the Simon Says game. On each round start it fetches one 12-bit pattern and its "Simon says" flag from the pattern source over a req/ack handshake, then runs a countdown window whose length shrinks with the round number while driving a 16-LED thermometer bar. At expiry it samples the player's switch input and reports completion to the top-level game FSM, which does the pass/fail evaluation.

## Interface
- TICK_DIV, 4, clk cycles per countdown tick (≥2)
- BASE_TICKS, 16, window length in ticks at round 0 (1..16)
- STEP_TICKS, 1, ticks removed per round
- MIN_TICKS, 4, floor on window length (1..BASE_TICKS)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle round-start pulse; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done
- round  in  5  current round number, sampled on the accepted start
- pat_req  out  1  pattern request, held until ack
- pat_ack  in  1  pattern source acknowledge, data valid same cycle
- pat_data  in  12  three 4-bit digits {d2,d1,d0}
- pat_say  in  1  Simon-says flag
- in  in  16  player switches
- pattern  out  12  latched pattern
- say  out  1  latched Simon-says flag
- led  out  16  countdown thermometer
- sample  out  16  player input latched at window expiry
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, COUNT, SAMPLE, DONE.
- IDLE: on start, latch round and go to FETCH. Start is ignored in every other state.
- FETCH: pat_req=1. On the pat_ack cycle, latch pattern/say, load remaining=window and the prescaler with 0, then go to COUNT. The FETCH state has no timeout.
- Window: window = max(MIN_TICKS, BASE_TICKS − round·STEP_TICKS).
  - Computed at ≥10 bits unsigned, so the subtraction saturates at MIN_TICKS and never wraps.
- COUNT:
  - led = (1<<remaining)−1, so remaining=16 gives 16'hFFFF.
  - The prescaler counts 0..TICK_DIV−1. When it wraps, remaining decrements.
  - When remaining becomes 0, go to SAMPLE.
- SAMPLE: led=0. Latch sample<=in, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Output retention: pattern, say and sample hold their values until overwritten by the next round (pattern/say at the next ack, sample at the next SAMPLE).
- Abort:
  - In any non-IDLE state, go to IDLE next cycle. pat_req drops and led=0.
  - Latched outputs are not updated by the aborted round; no done.
  - Abort has priority over pat_ack and over tick expiry in the same cycle.
  - Abort in IDLE has no effect; start+abort in the same IDLE cycle leaves the block in IDLE.
- pat_ack outside FETCH is ignored.
- Reset values: state=IDLE; pat_req=0, pattern=0, say=0, led=0, sample=0, busy=0, done=0; prescaler=0, remaining=0.

## Timing
- Start accepted in cycle N: FETCH and pat_req=1 in cycle N+1.
- Ack in cycle M: COUNT in M+1 with the full bar.
- COUNT lasts exactly window·TICK_DIV cycles. The bar loses one LED every TICK_DIV cycles.
- SAMPLE in cycle M+1+window·TICK_DIV; done in the following cycle; IDLE and busy=0 in the cycle after that.
- Start is accepted again in the first IDLE cycle.
- All outputs are registered. led, busy and pat_req are decoded from registered state and counters.
- Async reset mid-round: immediate return to the reset values.

## Structure
- The shared game package holds the state typedef (simon_rc_state_t) and the default constants (16 LEDs, 12-bit pattern, 5-bit round).
- One sub-module, simon_tick_prescaler: a TICK_DIV counter with a clear input and a one-cycle tick output.
- The window computation and the thermometer decode stay inline.

## Test plan
All scenarios use default parameters.
- Reset mid-COUNT:
  - Stimulus: assert rst while the bar is partly lit.
  - Required: all outputs 0 and state IDLE immediately; a new start works normally.
- Round 0, ack 2 cycles after pat_req, pat_data=12'h3A5, say=1, in=16'h0421:
  - COUNT lasts 64 cycles; led steps FFFF→7FFF→…→0001→0000.
  - sample=16'h0421, pattern=12'h3A5, say=1, one done pulse.
- Round 14:
  - Window saturates at MIN_TICKS: 4 ticks = 16 COUNT cycles, first bar 16'h000F.
  - Round 31 also gives 4 ticks, with no wrap.
- Abort scenarios:
  - Abort in FETCH with ack in the same cycle: no latch, pattern keeps its old value, IDLE next cycle, no done.
  - Abort mid-COUNT: led=0 next cycle, no done.
- Start ignored while busy:
  - Pulse start during COUNT.
  - Required: round timing unchanged, exactly one done.
- Back-to-back rounds:
  - Start in the first IDLE cycle after done.
  - Required: pat_req rises the next cycle; the previous sample holds until the new SAMPLE.

Source files
------------

// File: rtl/simon_round_ctrl_pkg.sv
// Shared Simon game definitions: round-controller state encoding and default widths.
package simon_round_ctrl_pkg;

  localparam int LED_W   = 16;
  localparam int PAT_W   = 12;
  localparam int ROUND_W = 5;
  localparam int WIN_W   = 10;
  localparam int REM_W   = $clog2(LED_W + 1);

  typedef logic [2:0] simon_rc_state_t;

  localparam simon_rc_state_t ST_IDLE   = 3'd0;
  localparam simon_rc_state_t ST_FETCH  = 3'd1;
  localparam simon_rc_state_t ST_COUNT  = 3'd2;
  localparam simon_rc_state_t ST_SAMPLE = 3'd3;
  localparam simon_rc_state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/simon_round_ctrl_prescaler.sv
// Countdown tick prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
module simon_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: fetch a pattern, run a shrinking countdown bar, sample the player.
module simon_round_ctrl
  import simon_round_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int BASE_TICKS = 16,
  parameter int STEP_TICKS = 1,
  parameter int MIN_TICKS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROUND_W-1:0] round,
  output logic               pat_req,
  input  logic               pat_ack,
  input  logic [PAT_W-1:0]   pat_data,
  input  logic               pat_say,
  input  logic [LED_W-1:0]   in,
  output logic [PAT_W-1:0]   pattern,
  output logic               say,
  output logic [LED_W-1:0]   led,
  output logic [LED_W-1:0]   sample,
  output logic               busy,
  output logic               done
);

  localparam logic [LED_W:0] BAR_ONE = (LED_W + 1)'(1);

  simon_rc_state_t    state;
  logic [ROUND_W-1:0] round_q;
  logic [REM_W-1:0]   remaining;
  logic [WIN_W-1:0]   round_ticks;
  logic [WIN_W-1:0]   window;
  logic [LED_W:0]     bar_full;
  logic               tick;
  logic               presc_clear;

  // Compare before subtracting so late rounds clamp to the floor instead of wrapping.
  assign round_ticks = WIN_W'(round_q) * WIN_W'(STEP_TICKS);

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    window = WIN_W'(MIN_TICKS);
    if (round_ticks + WIN_W'(MIN_TICKS) < WIN_W'(BASE_TICKS)) begin
      window = WIN_W'(BASE_TICKS) - round_ticks;
    end
  end

  assign presc_clear = (state != ST_COUNT) || abort;

  simon_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_q   <= '0;
      remaining <= '0;
      pattern   <= '0;
      say       <= 1'b0;
      sample    <= '0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            round_q <= round;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (pat_ack) begin
            pattern   <= pat_data;
            say       <= pat_say;
            remaining <= REM_W'(window);
            state     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (tick) begin
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          sample <= in;
          state  <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // One extra bit lets remaining == LED_W produce the all-ones bar.
  assign bar_full = (BAR_ONE << remaining) - BAR_ONE;
  assign led      = (state == ST_COUNT) ? bar_full[LED_W-1:0] : '0;
  assign pat_req  = (state == ST_FETCH);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: scoreboard of expected round results popped on done.
module tb_simon_round_ctrl;

  typedef struct packed {
    logic [11:0] pat;
    logic        say;
    logic [15:0] smp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  round = '0;
  logic        pat_req;
  logic        pat_ack = 1'b0;
  logic [11:0] pat_data = '0;
  logic        pat_say = 1'b0;
  logic [15:0] sw = '0;
  logic [11:0] pattern;
  logic        say;
  logic [15:0] led;
  logic [15:0] sample;
  logic        busy;
  logic        done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_seen = 0;
  int   done_expected = 0;
  exp_t sb_q[$];
  logic [15:0] last_sample = '0;
  logic [11:0] last_pat = '0;
  logic        last_say = 1'b0;

  simon_round_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .round    (round),
    .pat_req  (pat_req),
    .pat_ack  (pat_ack),
    .pat_data (pat_data),
    .pat_say  (pat_say),
    .in       (sw),
    .pattern  (pattern),
    .say      (say),
    .led      (led),
    .sample   (sample),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] thermo(input int n);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < n && k < 16; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int window_of(input int r);
    int w;
    w = 16 - r;
    if (w < 4) w = 4;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending round.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pattern", 32'(pattern), 32'(e.pat));
        check("sb_say", 32'(say), 32'(e.say));
        check("sb_sample", 32'(sample), 32'(e.smp));
      end
    end
  end

  task automatic run_round(input logic [4:0] r, input int ack_dly, input logic [11:0] d,
                           input logic s, input logic [15:0] val, input bit poke_start);
    int w;
    w = window_of(int'(r));
    start = 1'b1;
    round = r;
    step();
    start = 1'b0;
    round = ~r;
    check("fetch_req", 32'(pat_req), 32'd1);
    check("fetch_busy", 32'(busy), 32'd1);
    repeat (ack_dly) begin
      step();
      check("req_held", 32'(pat_req), 32'd1);
    end
    pat_ack  = 1'b1;
    pat_data = d;
    pat_say  = s;
    sw       = val;
    sb_q.push_back('{pat: d, say: s, smp: val});
    done_expected++;
    step();
    pat_ack  = 1'b0;
    pat_data = 12'($urandom);
    pat_say  = ~s;
    check("req_drop", 32'(pat_req), 32'd0);
    check("pattern_latch", 32'(pattern), 32'(d));
    check("say_latch", 32'(say), 32'(s));
    check("sample_hold", 32'(sample), 32'(last_sample));
    for (int i = 0; i < w * 4; i++) begin
      check("count_led", 32'(led), 32'(thermo(w - i / 4)));
      check("count_done", 32'(done), 32'd0);
      if (poke_start && i == 5) begin
        start = 1'b1;
        round = 5'd0;
      end
      step();
      start = 1'b0;
    end
    check("sample_led", 32'(led), 32'd0);
    check("sample_busy", 32'(busy), 32'd1);
    check("sample_done", 32'(done), 32'd0);
    step();
    check("done_pulse", 32'(done), 32'd1);
    sw = ~val;
    step();
    check("done_drop", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("sample_val", 32'(sample), 32'(val));
    last_sample = val;
    last_pat    = d;
    last_say    = s;
  endtask

  initial begin
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pat_req", 32'(pat_req), 32'd0);
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_say", 32'(say), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // pat_ack while idle is ignored; start with abort stays idle.
    pat_ack = 1'b1; pat_data = 12'hABC; pat_say = 1'b1;
    step();
    pat_ack = 1'b0; pat_say = 1'b0;
    check("idle_ack_pattern", 32'(pattern), 32'd0);
    check("idle_ack_say", 32'(say), 32'd0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);
    step();
    check("start_abort_req", 32'(pat_req), 32'd0);

    // Round 0, then back-to-back rounds started in the first idle cycle.
    run_round(5'd0, 2, 12'h3A5, 1'b1, 16'h0421, 1'b0);
    run_round(5'd3, 0, 12'h5C7, 1'b0, 16'hBEEF, 1'b1);
    run_round(5'd14, 1, 12'h012, 1'b1, 16'h8001, 1'b0);
    run_round(5'd31, 3, 12'hFED, 1'b0, 16'h7FFE, 1'b0);

    // Abort in FETCH coinciding with ack.
    start = 1'b1; round = 5'd2;
    step();
    start = 1'b0;
    check("abf_req", 32'(pat_req), 32'd1);
    pat_ack = 1'b1; pat_data = ~last_pat; pat_say = ~last_say; abort = 1'b1;
    step();
    pat_ack = 1'b0; abort = 1'b0;
    check("abf_busy", 32'(busy), 32'd0);
    check("abf_req_drop", 32'(pat_req), 32'd0);
    check("abf_pattern", 32'(pattern), 32'(last_pat));
    check("abf_say", 32'(say), 32'(last_say));
    repeat (3) step();
    check("abf_no_done_busy", 32'(busy), 32'd0);

    // Abort mid-COUNT.
    start = 1'b1; round = 5'd0;
    step();
    start = 1'b0;
    pat_ack = 1'b1; pat_data = 12'h111; pat_say = 1'b1; sw = 16'h1234;
    step();
    pat_ack = 1'b0;
    repeat (9) step();
    check("abc_led_before", 32'(led), 32'(thermo(14)));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abc_led", 32'(led), 32'd0);
    check("abc_busy", 32'(busy), 32'd0);
    check("abc_sample", 32'(sample), 32'(last_sample));
    repeat (80) step();
    check("abc_idle", 32'(busy), 32'd0);

    // Async reset while the bar is partly lit.
    start = 1'b1; round = 5'd1;
    step();
    start = 1'b0;
    pat_ack = 1'b1; pat_data = 12'h777; pat_say = 1'b1;
    step();
    pat_ack = 1'b0;
    repeat (10) step();
    check("rmc_led_before", 32'(led), 32'(thermo(13)));
    rst = 1'b1;
    #1;
    check("rmc_led", 32'(led), 32'd0);
    check("rmc_busy", 32'(busy), 32'd0);
    check("rmc_pattern", 32'(pattern), 32'd0);
    check("rmc_say", 32'(say), 32'd0);
    check("rmc_sample", 32'(sample), 32'd0);
    check("rmc_req", 32'(pat_req), 32'd0);
    check("rmc_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    last_sample = '0;
    step();
    run_round(5'd5, 1, 12'h9B4, 1'b1, 16'h00F0, 1'b0);

    repeat (3) step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(done_expected));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
